mant_add_stage: RTL and testbench

MANT_ADD_STAGE -- requirements
Module: mant_add_stage

---
 rtl/mant_add_stage.sv | 152 +++++++++++++++
 tb/tb_mant_add_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mant_add_stage.sv
// mant_add_stage: two-register mantissa adder stage of an FMA datapath.
// S1 captures the aligned addend and the mantissa product; S2 holds the
// sign-corrected sum magnitude plus sign, exponent, sticky and zero flags.
// Valid/ready handshake with full throughput and stall-safe outputs.
// Optional build macro MANT_ADD_LZC_EN adds a registered leading-zero count
// of the magnitude; without it Lzc_o is tied to 0.
module mant_add_stage #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic [74:0]                   A_Mant_aligned_i,
  input  logic [2*(PARM_MANT+1)-1:0]    Prod_i,
  input  logic                          Sub_Sign_i,
  input  logic                          Sign_aligned_i,
  input  logic [PARM_EXP+1:0]           Exp_aligned_i,
  input  logic                          Mant_sticky_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [73:0]                   Sum_Mag_o,
  output logic                          Sign_o,
  output logic                          Sign_flip_o,
  output logic [PARM_EXP+1:0]           Exp_o,
  output logic                          Sticky_o,
  output logic                          Zero_o,
  output logic [6:0]                    Lzc_o
);

  localparam int PW = 2*(PARM_MANT+1);  // product width
  localparam int AW = 75;               // raw sum width incl. sign extension
  localparam int MW = 74;               // magnitude width
  localparam int EW = PARM_EXP+2;       // exponent width

  typedef struct packed {
    logic [AW-1:0] addend;
    logic [PW-1:0] prod;
    logic          sub;
    logic          sgn;
    logic [EW-1:0] exp;
    logic          stk;
  } s1_t;

  typedef struct packed {
    logic [MW-1:0] mag;
    logic          sgn;
    logic          flip;
    logic [EW-1:0] exp;
    logic          stk;
    logic          zero;
  } s2_t;

  // vld_pipe[1] = S1 holds a beat, vld_pipe[2] = S2 holds a result
  logic [2:1]    vld_pipe;
  s1_t           s1_in, s1_q;
  s2_t           s2_d, s2_q;
  logic          accept, adv;
  logic [AW-1:0] raw;
  logic          flip;
  logic [MW-1:0] mag;

  // A stalled S2 only blocks input when S1 is also occupied.
  assign In_ready_o = ~vld_pipe[1] | ~vld_pipe[2] | Out_ready_i;
  assign accept     = In_valid_i & In_ready_o;
  assign adv        = vld_pipe[1] & (~vld_pipe[2] | Out_ready_i);

  assign s1_in = '{addend: A_Mant_aligned_i,
                   prod:   Prod_i,
                   sub:    Sub_Sign_i,
                   sgn:    Sign_aligned_i,
                   exp:    Exp_aligned_i,
                   stk:    Mant_sticky_i};

  // Valid flags: S1 fills on accept and empties on advance; S2 fills on
  // advance and empties when downstream takes the result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept | (vld_pipe[1] & ~adv);
      vld_pipe[2] <= adv    | (vld_pipe[2] & ~Out_ready_i);
    end
  end

  // S1 data register loads only on an accepted beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) s1_q <= '0;
    else if (accept) s1_q <= s1_in;
  end

  // Raw sum and sign correction. The +1 completes the two's-complement of
  // the one's-complemented addend; a set sticky means bits were shifted out
  // of the addend, so the borrow into the kept bits cancels that +1.
  always_comb begin
    raw  = s1_q.addend
         + {{(AW-PW){1'b0}}, s1_q.prod}
         + {{(AW-1){1'b0}}, s1_q.sub & ~s1_q.stk};
    flip = s1_q.sub & raw[AW-1];
    mag  = flip ? (~raw[MW-1:0] + {{(MW-1){1'b0}}, 1'b1}) : raw[MW-1:0];
  end

  // S2-bound result record.
  always_comb begin
    s2_d      = '0;
    s2_d.mag  = mag;
    s2_d.flip = flip;
    s2_d.sgn  = s1_q.sgn ^ flip;
    s2_d.exp  = s1_q.exp;
    s2_d.stk  = s1_q.stk;
    s2_d.zero = (mag == '0) & ~s1_q.stk;
  end

  // S2 result register loads only when S1 advances, so outputs hold
  // steady while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) s2_q <= '0;
    else if (adv) s2_q <= s2_d;
  end

  assign Out_valid_o = vld_pipe[2];
  assign Sum_Mag_o   = s2_q.mag;
  assign Sign_o      = s2_q.sgn;
  assign Sign_flip_o = s2_q.flip;
  assign Exp_o       = s2_q.exp;
  assign Sticky_o    = s2_q.stk;
  assign Zero_o      = s2_q.zero;

`ifdef MANT_ADD_LZC_EN
  logic [6:0] lzc_d, lzc_q;

  // Leading-zero count: the highest set bit wins; 74 for a zero magnitude.
  always_comb begin
    lzc_d = 7'd74;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lzc_d = 7'(MW - 1 - i);
    end
  end

  // Count travels with the magnitude into S2.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lzc_q <= '0;
    else if (adv) lzc_q <= lzc_d;
  end

  assign Lzc_o = lzc_q;
`else
  assign Lzc_o = '0;
`endif

endmodule

// File: tb/tb_mant_add_stage.sv
// tb_mant_add_stage: directed vector table plus backpressure and
// mid-flight reset sequences for mant_add_stage (default parameters).
module tb_mant_add_stage;

`ifdef MANT_ADD_LZC_EN
  localparam bit LZC_ON = 1'b1;
`else
  localparam bit LZC_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        In_valid_i;
  logic        In_ready_o;
  logic [74:0] A_Mant_aligned_i;
  logic [47:0] Prod_i;
  logic        Sub_Sign_i;
  logic        Sign_aligned_i;
  logic [9:0]  Exp_aligned_i;
  logic        Mant_sticky_i;
  logic        Out_valid_o;
  logic        Out_ready_i;
  logic [73:0] Sum_Mag_o;
  logic        Sign_o;
  logic        Sign_flip_o;
  logic [9:0]  Exp_o;
  logic        Sticky_o;
  logic        Zero_o;
  logic [6:0]  Lzc_o;

  int checks = 0;
  int errors = 0;

  mant_add_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .A_Mant_aligned_i(A_Mant_aligned_i), .Prod_i(Prod_i),
    .Sub_Sign_i(Sub_Sign_i), .Sign_aligned_i(Sign_aligned_i),
    .Exp_aligned_i(Exp_aligned_i), .Mant_sticky_i(Mant_sticky_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .Sum_Mag_o(Sum_Mag_o), .Sign_o(Sign_o), .Sign_flip_o(Sign_flip_o),
    .Exp_o(Exp_o), .Sticky_o(Sticky_o), .Zero_o(Zero_o), .Lzc_o(Lzc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [74:0] a;
    logic [47:0] prod;
    logic        sub;
    logic        sgn;
    logic [9:0]  exp;
    logic        stk;
    logic [73:0] mag;
    logic        flip;
    logic        osgn;
    logic        zero;
    logic [6:0]  lzc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    A_Mant_aligned_i = v.a;
    Prod_i           = v.prod;
    Sub_Sign_i       = v.sub;
    Sign_aligned_i   = v.sgn;
    Exp_aligned_i    = v.exp;
    Mant_sticky_i    = v.stk;
  endtask

  // One beat through an empty pipe: accept, one cycle in S1, then S2.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk_i);
    Out_ready_i = 1'b1;
    In_valid_i  = 1'b1;
    drive(v);
    #1 chk($sformatf("v%0d_in_ready", idx), In_ready_o, 1);
    @(negedge clk_i);
    In_valid_i = 1'b0;
    chk($sformatf("v%0d_lat1_valid", idx), Out_valid_o, 0);
    @(negedge clk_i);
    chk($sformatf("v%0d_valid", idx), Out_valid_o, 1);
    chk($sformatf("v%0d_mag", idx),   Sum_Mag_o,   v.mag);
    chk($sformatf("v%0d_flip", idx),  Sign_flip_o, v.flip);
    chk($sformatf("v%0d_sign", idx),  Sign_o,      v.osgn);
    chk($sformatf("v%0d_exp", idx),   Exp_o,       v.exp);
    chk($sformatf("v%0d_stk", idx),   Sticky_o,    v.stk);
    chk($sformatf("v%0d_zero", idx),  Zero_o,      v.zero);
    chk($sformatf("v%0d_lzc", idx),   Lzc_o,       LZC_ON ? v.lzc : 7'd0);
  endtask

  vec_t        bp[5];
  logic [73:0] bp_mag[5];

  initial begin
    // a, prod, sub, sgn, exp, stk | mag, flip, osgn, zero, lzc
    vt[0] = '{{1'b0, 24'hC00000, 50'd0}, 48'h400000000000, 0, 0, 10'h07F, 0,
              {24'hC00000, 50'd0} + 74'h400000000000, 0, 0, 0, 7'd0};
    vt[1] = '{{1'b1, ~{24'h800000, 50'd0}}, 48'hC00000000000, 1, 0, 10'h081, 0,
              {24'h800000, 50'd0} - 74'hC00000000000, 1, 1, 0, 7'd1};
    vt[2] = '{{1'b1, ~{26'd0, 48'h123456789ABC}}, 48'h123456789ABC, 1, 1, 10'h100, 0,
              74'd0, 0, 1, 1, 7'd74};
    vt[3] = '{{1'b1, ~{26'd0, 48'h123456789ABC}}, 48'h123456789ABC, 1, 1, 10'h101, 1,
              74'd1, 1, 0, 0, 7'd73};
    vt[4] = '{{1'b1, ~74'd5}, 48'd9, 1, 0, 10'h2AA, 0, 74'd4, 0, 0, 0, 7'd71};
    vt[5] = '{{1'b1, ~74'd5}, 48'd9, 1, 1, 10'h155, 1, 74'd3, 0, 1, 0, 7'd72};
    vt[6] = '{{1'b0, {74{1'b1}}}, 48'd1, 0, 1, 10'h3FF, 0, 74'd0, 0, 1, 1, 7'd74};
    vt[7] = '{75'd0, 48'd0, 0, 0, 10'h001, 1, 74'd0, 0, 0, 0, 7'd74};

    for (int i = 0; i < 5; i++) begin
      bp[i] = '{{1'b0, 74'(100 * (i + 1))}, 48'(i), 0, 0, 10'(i + 3), 0,
                74'd0, 0, 0, 0, 7'd0};
      bp_mag[i] = 74'(100 * (i + 1) + i);
    end

    rst_n_i = 1'b0;
    In_valid_i = 1'b0;
    Out_ready_i = 1'b1;
    drive(vt[7]);
    #12;
    chk("rst_out_valid", Out_valid_o, 0);
    chk("rst_in_ready",  In_ready_o,  1);
    chk("rst_mag",       Sum_Mag_o,   0);
    chk("rst_sign",      Sign_o,      0);
    chk("rst_flip",      Sign_flip_o, 0);
    chk("rst_exp",       Exp_o,       0);
    chk("rst_zero",      Zero_o,      0);
    chk("rst_lzc",       Lzc_o,       0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Backpressure: five back-to-back beats, downstream stalls cycles 3..6.
    begin
      int sent = 0, rcv = 0, low = 0;
      logic        stall_prev = 1'b0;
      logic [73:0] pmag = '0;
      logic [9:0]  pexp = '0;
      for (int c = 0; c < 40 && rcv < 5; c++) begin
        @(negedge clk_i);
        Out_ready_i = !(c >= 3 && c <= 6);
        In_valid_i  = (sent < 5);
        if (sent < 5) drive(bp[sent]);
        #1;
        if (stall_prev) begin
          chk("bp_hold_valid", Out_valid_o, 1);
          chk("bp_hold_mag",   Sum_Mag_o,   pmag);
          chk("bp_hold_exp",   Exp_o,       pexp);
        end
        if (!In_ready_o) low++;
        if (Out_valid_o && Out_ready_i) begin
          chk($sformatf("bp%0d_mag", rcv), Sum_Mag_o, bp_mag[rcv]);
          chk($sformatf("bp%0d_exp", rcv), Exp_o,     10'(rcv + 3));
          rcv++;
        end
        stall_prev = Out_valid_o && !Out_ready_i;
        pmag = Sum_Mag_o;
        pexp = Exp_o;
        if (In_valid_i && In_ready_o) sent++;
      end
      In_valid_i = 1'b0;
      chk("bp_beats_out",       rcv, 5);
      chk("bp_in_ready_low_cy", low, 4);
    end

    // Mid-flight reset with both stages full.
    begin
      int seen = 0;
      @(negedge clk_i);
      Out_ready_i = 1'b0;
      In_valid_i  = 1'b1;
      drive(vt[0]);
      @(negedge clk_i);
      drive(vt[1]);
      @(negedge clk_i);
      In_valid_i = 1'b0;
      #1;
      chk("mr_full_valid", Out_valid_o, 1);
      chk("mr_full_ready", In_ready_o,  0);
      rst_n_i = 1'b0;
      #1;
      chk("mr_rst_valid", Out_valid_o, 0);
      chk("mr_rst_ready", In_ready_o,  1);
      chk("mr_rst_mag",   Sum_Mag_o,   0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      Out_ready_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk_i);
        if (Out_valid_o) seen++;
      end
      chk("mr_no_stale_beat", seen, 0);
      run_vec(vt[4], 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
